// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pkg
// Brief    : Shared NTT constants and the bit-reversal permutation FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int N    = 512;     // polynomial length
    localparam int LOGN = 9;       // log2(N), coefficient RAM address width
    localparam int DW   = 14;      // coefficient width
    localparam int Q    = 12289;   // NTT modulus

    // Permutation controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } perm_state_e;

endpackage : ntt_pkg
`default_nettype wire

// File: rtl/addr_bitrev.sv
`default_nettype none
// ============================================================================
// Module   : addr_bitrev
// Brief    : Pure wire reversal of an address (out[k] = in[LOGN-1-k]).
// Revision : 1.0 - initial release
// ============================================================================
module addr_bitrev #(
    parameter int LOGN = 9
) (
    input  logic [LOGN-1:0] addr_in,
    output logic [LOGN-1:0] addr_out
);

    // Each output bit is simply the mirrored input bit; no logic, only routing.
    generate
        for (genvar k = 0; k < LOGN; k++) begin : g_rev
            assign addr_out[k] = addr_in[LOGN-1-k];
        end
    endgenerate

endmodule : addr_bitrev
`default_nettype wire

// File: rtl/bitrev_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_perm_ctrl
// Brief    : In-place bit-reversal permutation of the NTT coefficient RAM.
//            Walks i = 0..N-1 and swaps RAM[i] / RAM[bitrev(i)] when i < r.
// Revision : 1.0 - initial release
// ============================================================================
module bitrev_perm_ctrl #(
    parameter int N      = ntt_pkg::N,
    parameter int LOGN   = ntt_pkg::LOGN,
    parameter int DW     = ntt_pkg::DW,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    input  logic [DW-1:0]   rd_data_a,
    input  logic [DW-1:0]   rd_data_b,
    output logic            wr_en,
    output logic [DW-1:0]   wr_data_a,
    output logic [DW-1:0]   wr_data_b
);

    import ntt_pkg::*;

    // Latency counter only needs to count the RD_LAT-1 WAIT cycles.
    localparam int LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int LAT_LAST = (RD_LAT >= 2) ? (RD_LAT - 2) : 0;
    localparam logic [LOGN-1:0] I_LAST = LOGN'(N - 1);

    perm_state_e        state_q, state_d;
    logic [LOGN-1:0]    i_q, i_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [LOGN-1:0]    rev_i;

    // Partner address of the current index.
    addr_bitrev #(
        .LOGN (LOGN)
    ) u_addr_bitrev (
        .addr_in  (i_q),
        .addr_out (rev_i)
    );

    // State, index and latency registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state and output decode. Addresses follow i_q directly, so they are
    // zero whenever the controller sits in IDLE (i_q is cleared on exit).
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        lat_d     = lat_q;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        wr_data_a = '0;
        wr_data_b = '0;
        addr_a    = i_q;
        addr_b    = rev_i;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    i_d     = '0;
                end
            end

            ST_SCAN: begin
                busy = 1'b1;
                if (i_q < rev_i) begin
                    // Only the lower index of a pair triggers the swap.
                    rd_en   = 1'b1;
                    lat_d   = '0;
                    state_d = (RD_LAT == 1) ? ST_WRITE : ST_WAIT;
                end else if (i_q == I_LAST) begin
                    state_d = ST_FIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end

            ST_WAIT: begin
                busy = 1'b1;
                if (lat_q == LAT_W'(LAT_LAST)) begin
                    state_d = ST_WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            ST_WRITE: begin
                // Cross-write the captured read data; i_q < N-1 here always.
                busy      = 1'b1;
                wr_en     = 1'b1;
                wr_data_a = rd_data_b;
                wr_data_b = rd_data_a;
                i_d       = i_q + 1'b1;
                state_d   = ST_SCAN;
            end

            ST_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                i_d     = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                i_d     = '0;
            end
        endcase
    end

endmodule : bitrev_perm_ctrl
`default_nettype wire

// File: tb/tb_bitrev_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitrev_perm_ctrl
// Brief    : Directed bench for bitrev_perm_ctrl with RD_LAT=1 and RD_LAT=3
//            instances, each backed by a behavioural dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitrev_perm_ctrl;

    localparam int N    = 512;
    localparam int LOGN = 9;
    localparam int DW   = 14;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT = 1 instance
    logic            start1 = 1'b0;
    logic            busy1, done1, rd_en1, wr_en1;
    logic [LOGN-1:0] addr_a1, addr_b1;
    logic [DW-1:0]   rd_a1, rd_b1, wd_a1, wd_b1;

    // RD_LAT = 3 instance
    logic            start3 = 1'b0;
    logic            busy3, done3, rd_en3, wr_en3;
    logic [LOGN-1:0] addr_a3, addr_b3;
    logic [DW-1:0]   rd_a3, rd_b3, wd_a3, wd_b3;

    bitrev_perm_ctrl #(.N(N), .LOGN(LOGN), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .addr_a(addr_a1), .addr_b(addr_b1),
        .rd_data_a(rd_a1), .rd_data_b(rd_b1),
        .wr_en(wr_en1), .wr_data_a(wd_a1), .wr_data_b(wd_b1)
    );

    bitrev_perm_ctrl #(.N(N), .LOGN(LOGN), .DW(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .rd_en(rd_en3), .addr_a(addr_a3), .addr_b(addr_b3),
        .rd_data_a(rd_a3), .rd_data_b(rd_b3),
        .wr_en(wr_en3), .wr_data_a(wd_a3), .wr_data_b(wd_b3)
    );

    // Behavioural RAMs, preload image and monitor counters
    logic [DW-1:0] ram1 [N];
    logic [DW-1:0] ram3 [N];
    logic [DW-1:0] pre  [N];
    logic [DW-1:0] orig [N];
    logic          load1 = 1'b0;
    logic          load3 = 1'b0;
    logic [DW-1:0] p3a [3];
    logic [DW-1:0] p3b [3];

    int wr_cnt1 = 0, wr_cnt3 = 0, done_cnt1 = 0, done_cnt3 = 0;
    int wbad1 = 0, wbad3 = 0, proto_bad = 0;

    int vectors = 0;
    int miscompares = 0;

    assign rd_b3 = p3b[2];
    assign rd_a3 = p3a[2];

    always @(posedge clk) begin
        if (load1) begin
            for (int k = 0; k < N; k++) ram1[k] <= pre[k];
        end else if (wr_en1) begin
            ram1[addr_a1] <= wd_a1;
            ram1[addr_b1] <= wd_b1;
        end
        rd_a1 <= rd_en1 ? ram1[addr_a1] : 'x;
        rd_b1 <= rd_en1 ? ram1[addr_b1] : 'x;
    end

    always @(posedge clk) begin
        if (load3) begin
            for (int k = 0; k < N; k++) ram3[k] <= pre[k];
        end else if (wr_en3) begin
            ram3[addr_a3] <= wd_a3;
            ram3[addr_b3] <= wd_b3;
        end
        p3a[0] <= rd_en3 ? ram3[addr_a3] : 'x;
        p3b[0] <= rd_en3 ? ram3[addr_b3] : 'x;
        p3a[1] <= p3a[0];
        p3b[1] <= p3b[0];
        p3a[2] <= p3a[1];
        p3b[2] <= p3b[1];
    end

    // Protocol and write-data monitor: a write must carry the partner's value.
    always @(posedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (done3) done_cnt3 <= done_cnt3 + 1;
        if (wr_en1) begin
            wr_cnt1 <= wr_cnt1 + 1;
            if (wd_a1 !== ram1[addr_b1] || wd_b1 !== ram1[addr_a1]) wbad1 <= wbad1 + 1;
        end
        if (wr_en3) begin
            wr_cnt3 <= wr_cnt3 + 1;
            if (wd_a3 !== ram3[addr_b3] || wd_b3 !== ram3[addr_a3]) wbad3 <= wbad3 + 1;
        end
        if ((rd_en1 && wr_en1) || ((rd_en1 || wr_en1) && addr_a1 == addr_b1) ||
            (rd_en3 && wr_en3) || ((rd_en3 || wr_en3) && addr_a3 == addr_b3))
            proto_bad <= proto_bad + 1;
    end

    function automatic int brev(input int v);
        int r = 0;
        for (int k = 0; k < LOGN; k++) if (v & (1 << k)) r |= 1 << (LOGN - 1 - k);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_ram(input bit which);
        @(negedge clk);
        if (which) load3 = 1'b1; else load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        load3 = 1'b0;
    endtask

    // Pulse (or hold) start, then count cycles: cycle 1 is the first cycle
    // after the accept edge; returns the cycle in which done is seen.
    task automatic run_dut(input bit which, input bit hold, output int cyc);
        @(negedge clk);
        if (which) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        if (!hold) begin
            start1 = 1'b0;
            start3 = 1'b0;
        end
        cyc = 1;
        while (!(which ? done3 : done1) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic int ram_mism(input bit which, input bit permuted);
        int m = 0;
        for (int k = 0; k < N; k++) begin
            logic [DW-1:0] e;
            e = permuted ? pre[brev(k)] : orig[k];
            if ((which ? ram3[k] : ram1[k]) !== e) m++;
        end
        return m;
    endfunction

    initial begin
        int cyc, w0, d0, busy_seen;

        // ---- Reset then idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy1}, 0);
        check("rst_done_rd_wr", {29'd0, done1, rd_en1, wr_en1}, 0);
        check("rst_addr", {14'd0, addr_a1, addr_b1}, 0);
        check("rst_wdata", {4'd0, wd_a1, wd_b1}, 0);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy1 || busy3 || done1 || rd_en1 || wr_en1) busy_seen++;
        end
        check("idle_100", busy_seen, 0);

        // ---- Full run, RAM[k] = k
        for (int k = 0; k < N; k++) pre[k] = DW'(k);
        load_ram(1'b0);
        w0 = wr_cnt1;
        d0 = done_cnt1;
        run_dut(1'b0, 1'b0, cyc);
        check("run1_done_cycle", cyc, 753);
        @(negedge clk);
        check("run1_done_pulse", {31'd0, done1}, 0);
        check("run1_busy_after", {31'd0, busy1}, 0);
        check("run1_done_count", done_cnt1 - d0, 1);
        check("ram_256", ram1[256], 1);
        check("ram_1", ram1[1], 256);
        check("ram_3", ram1[3], 384);
        check("ram_257", ram1[257], 257);
        check("run1_wr_count", wr_cnt1 - w0, 240);
        check("run1_full_ram", ram_mism(1'b0, 1'b1), 0);

        // ---- Involution on a random preload
        for (int k = 0; k < N; k++) begin
            pre[k]  = DW'($urandom_range(0, 12288));
            orig[k] = pre[k];
        end
        load_ram(1'b0);
        run_dut(1'b0, 1'b0, cyc);
        check("inv_first_cycle", cyc, 753);
        @(negedge clk);
        check("inv_mid_ram", ram_mism(1'b0, 1'b1), 0);
        run_dut(1'b0, 1'b0, cyc);
        check("inv_second_cycle", cyc, 753);
        @(negedge clk);
        check("inv_restored", ram_mism(1'b0, 1'b0), 0);

        // ---- RD_LAT = 3 instance on the random preload
        load_ram(1'b1);
        w0 = wr_cnt3;
        run_dut(1'b1, 1'b0, cyc);
        check("lat3_done_cycle", cyc, 1233);
        @(negedge clk);
        check("lat3_busy_after", {31'd0, busy3}, 0);
        check("lat3_wr_count", wr_cnt3 - w0, 240);
        check("lat3_ram", ram_mism(1'b1, 1'b1), 0);
        check("lat3_wdata", wbad3, 0);

        // ---- Start held high through a run
        d0 = done_cnt1;
        run_dut(1'b0, 1'b1, cyc);
        check("hold_done_cycle", cyc, 753);
        @(negedge clk);
        check("hold_done_count", done_cnt1 - d0, 1);
        check("hold_idle_gap", {31'd0, busy1}, 0);
        @(negedge clk);
        check("hold_restart", {31'd0, busy1}, 1);
        start1 = 1'b0;

        // ---- Asynchronous reset in cycle 300 of the restarted run
        repeat (299) @(negedge clk);
        d0 = done_cnt1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {busy1, done1, rd_en1, wr_en1, addr_a1, addr_b1, wd_a1[0], wd_b1[0]}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_no_done", done_cnt1 - d0, 0);
        run_dut(1'b0, 1'b0, cyc);
        check("arst_rerun_cycle", cyc, 753);
        @(negedge clk);

        check("wdata_rd1", wbad1, 0);
        check("protocol", proto_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bitrev_perm_ctrl
`default_nettype wire

// File: doc/bitrev_perm_ctrl.md
Name: bitrev_perm_ctrl

Overview:
- Sequential controller that performs the in-place bit-reversal permutation of a polynomial held in the NTT coefficient RAM.
- It walks every address i, computes r = bitrev(i), and swaps RAM[i] and RAM[r] once for each pair with i < r.
- Sits between the top-level NTT sequencer and the dual-port coefficient RAM. It runs before the forward NTT and after the inverse NTT.
- It is the consumer/driver side of the address-reversal mapping: it generates the mapping arithmetically and drives RAM read/write traffic.

Parameters:
- N, 512, polynomial length; must be a power of two.
- LOGN, 9, address width = log2(N).
- DW, 14, coefficient width (q = 12289).
- RD_LAT, 1, RAM read latency in cycles; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin a permutation; sampled only in IDLE.
- busy  out  1  high while a permutation is in progress.
- done  out  1  single-cycle pulse when the permutation completes.
- rd_en  out  1  read strobe for both RAM ports.
- addr_a  out  LOGN  RAM port A address (i), used for read and write.
- addr_b  out  LOGN  RAM port B address (r = bitrev(i)), used for read and write.
- rd_data_a  in  DW  port A read data, valid RD_LAT cycles after rd_en.
- rd_data_b  in  DW  port B read data, valid RD_LAT cycles after rd_en.
- wr_en  out  1  write strobe for both RAM ports.
- wr_data_a  out  DW  port A write data = captured rd_data_b.
- wr_data_b  out  DW  port B write data = captured rd_data_a.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; counter i = 0.
  - busy, done, rd_en and wr_en = 0; addr_a, addr_b, wr_data_a and wr_data_b = 0.
  - Reset mid-operation aborts immediately. RAM is left partially permuted, and no done pulse is issued.
- States: IDLE, SCAN, WAIT, WRITE, FIN.
- IDLE:
  - start=1 moves to SCAN with i=0 and busy=1.
  - start in any other state is ignored; no queuing.
- SCAN: r = bitrev(i), combinational from the registered i.
  - If i < r: assert rd_en with addr_a=i and addr_b=r. Go to WRITE if RD_LAT=1, else to WAIT.
  - If i >= r (palindrome or already-swapped pair): no RAM access. If i = N-1 go to FIN, else i <= i+1 and stay in SCAN.
- WAIT: hold addresses; rd_en=0. Stay RD_LAT-1 cycles using a small latency counter, then go to WRITE.
- WRITE:
  - wr_en=1 for exactly one cycle; addr_a=i, addr_b=r.
  - wr_data_a = rd_data_b and wr_data_b = rd_data_a, both sampled in this cycle.
  - Then i <= i+1 and return to SCAN. i = N-1 is never a swap source, so WRITE never ends the run.
- FIN: done=1 for one cycle, busy still 1. Next cycle: IDLE, busy=0, i=0.
- rd_en and wr_en are never high in the same cycle, and the two ports never address the same location in any cycle with rd_en or wr_en high.
- Counter i is LOGN bits and never wraps past N-1 within a run.
- Timing:
  - Each swap costs RD_LAT+1 cycles; each skip costs 1 cycle.
  - N=512: 240 swaps and 272 skips.
  - RD_LAT=1: 752 cycles in SCAN/WAIT/WRITE; done asserts 753 cycles after the start-accept edge.
- Running the block twice restores the original RAM contents (the permutation is an involution).

Decomposition:
- Shared package ntt_pkg holds:
  - N, LOGN, DW and Q=12289.
  - State enum encoding for IDLE/SCAN/WAIT/WRITE/FIN.
- One sub-module, addr_bitrev, parameterised by LOGN: a pure wire-reversal function (out[k] = in[LOGN-1-k]), replacing any table-based mapping. It is instantiated once on i.

Test Plan:
- Reset then idle: rst_n pulsed low with start=0 -> all outputs 0, busy stays 0 for 100 cycles.
- Full run, RD_LAT=1: RAM preloaded with RAM[k]=k; start pulsed -> done exactly 753 cycles after accept; RAM[256]=1, RAM[1]=256, RAM[3]=384, RAM[257]=257; wr_en count = 240.
- Involution: run twice back-to-back on a random preload -> final RAM equals the preload; second done again at 753 cycles.
- Start while busy: start held high during a run -> exactly one done; the next run begins only after returning to IDLE.
- RD_LAT=3 build (behavioural RAM model): done at 272 + 240*4 + 1 = 1233 cycles; write data matches the model.
- Async reset mid-run: rst_n low at cycle 300, asynchronous to clk -> outputs 0 immediately; no done; a new start completes a full 753-cycle run.
